// File: rtl/timer_irq_ctrl.sv
// Overflow-event to level-interrupt converter with ack handshake, event coalescing
// and a saturating missed-event counter. Coalescing is built only with TIMER_IRQ_COALESCE_EN.
module timer_irq_ctrl #(
   parameter int unsigned MISS_W   = 8,
   parameter int unsigned THRESH_W = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                ov_in,
   input  logic [THRESH_W-1:0] thresh,
   input  logic                irq_mask,
   input  logic                irq_ack,
   input  logic                clr_miss,
   output logic                irq,
   output logic                pending,
   output logic [THRESH_W-1:0] evt_cnt,
   output logic [MISS_W-1:0]   miss_cnt
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ASSERT   = 2'd1,
      WAIT_REL = 2'd2
   } state_t;

   state_t              state, state_nxt;
   logic                pending_q;
   logic [MISS_W-1:0]   miss_q, miss_base, miss_nxt;
   logic                miss_evt;
   logic                fire;
   logic [THRESH_W-1:0] evt_q, evt_nxt;

`ifdef TIMER_IRQ_COALESCE_EN
   logic [THRESH_W:0] evt_inc;
   logic [THRESH_W:0] thr_eff;

   // Compare one bit wider so evt_cnt+1 never wraps below the threshold.
   always_comb begin
      evt_inc = {1'b0, evt_q} + (THRESH_W+1)'(1);
      thr_eff = (thresh == '0) ? (THRESH_W+1)'(1) : {1'b0, thresh};
      fire    = (evt_inc >= thr_eff);
   end
`else
   logic unused_thresh;

   assign unused_thresh = ^thresh;
   assign fire          = 1'b1;
`endif

   always_comb begin
      state_nxt = state;
      evt_nxt   = evt_q;
      if (!en) begin
         state_nxt = IDLE;
         evt_nxt   = '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (ov_in) begin
                  if (fire) begin
                     state_nxt = ASSERT;
                     evt_nxt   = '0;
                  end else begin
`ifdef TIMER_IRQ_COALESCE_EN
                     evt_nxt = evt_inc[THRESH_W-1:0];
`else
                     evt_nxt = '0;
`endif
                  end
               end
            end
            ASSERT: begin
               if (irq_ack) state_nxt = WAIT_REL;
            end
            WAIT_REL: begin
               if (!irq_ack) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Clear takes effect first so a coincident miss leaves the count at one.
   always_comb begin
      miss_evt  = en && ov_in && (state != IDLE);
      miss_base = clr_miss ? '0 : miss_q;
      miss_nxt  = miss_base;
      if (miss_evt && (miss_base != '1)) miss_nxt = miss_base + MISS_W'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         pending_q <= 1'b0;
         evt_q     <= '0;
         miss_q    <= '0;
      end else begin
         state     <= state_nxt;
         pending_q <= (state_nxt == ASSERT);
         evt_q     <= evt_nxt;
         miss_q    <= miss_nxt;
      end
   end

   assign pending  = pending_q;
   assign irq      = pending_q & ~irq_mask;
   assign evt_cnt  = evt_q;
   assign miss_cnt = miss_q;

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Directed self-checking bench for timer_irq_ctrl; a second instance with MISS_W=2
// shares the stimulus to exercise miss counter saturation.
module tb_timer_irq_ctrl;

   logic       clk = 1'b0;
   logic       rst, en, ov_in, irq_mask, irq_ack, clr_miss;
   logic [3:0] thresh;

   logic       irq_a, pend_a, irq_b, pend_b;
   logic [3:0] evt_a, evt_b;
   logic [7:0] miss_a;
   logic [1:0] miss_b;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   timer_irq_ctrl #(.MISS_W(8), .THRESH_W(4)) dut_a (
      .clk(clk), .rst(rst), .en(en), .ov_in(ov_in), .thresh(thresh),
      .irq_mask(irq_mask), .irq_ack(irq_ack), .clr_miss(clr_miss),
      .irq(irq_a), .pending(pend_a), .evt_cnt(evt_a), .miss_cnt(miss_a)
   );

   timer_irq_ctrl #(.MISS_W(2), .THRESH_W(4)) dut_b (
      .clk(clk), .rst(rst), .en(en), .ov_in(ov_in), .thresh(thresh),
      .irq_mask(irq_mask), .irq_ack(irq_ack), .clr_miss(clr_miss),
      .irq(irq_b), .pending(pend_b), .evt_cnt(evt_b), .miss_cnt(miss_b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fire_one();
      thresh = 4'd1;
      ov_in  = 1'b1;
      tick();
      ov_in  = 1'b0;
   endtask

   task automatic release_ack();
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b0; en = 1'b0; ov_in = 1'b0; thresh = 4'd1;
      irq_mask = 1'b0; irq_ack = 1'b0; clr_miss = 1'b0;
      #3;
      total++; if (irq_a !== 1'b0) begin bad++; $display("FAIL rst_irq: got %0b want 0", irq_a); end
      total++; if (pend_a !== 1'b0) begin bad++; $display("FAIL rst_pend: got %0b want 0", pend_a); end
      total++; if (evt_a !== 4'd0) begin bad++; $display("FAIL rst_evt: got %0d want 0", evt_a); end
      total++; if (miss_a !== 8'd0) begin bad++; $display("FAIL rst_miss: got %0d want 0", miss_a); end
      tick();
      rst = 1'b1; en = 1'b1;
      tick();
   endtask

   task automatic test_mid_reset();
      fire_one();
      total++; if (irq_a !== 1'b1) begin bad++; $display("FAIL mr_irq_up: got %0b want 1", irq_a); end
      ov_in = 1'b1;
      repeat (5) tick();
      ov_in = 1'b0;
      total++; if (miss_a !== 8'd5) begin bad++; $display("FAIL mr_miss5: got %0d want 5", miss_a); end
      rst = 1'b0;
      #1;
      total++; if (irq_a !== 1'b0) begin bad++; $display("FAIL mr_irq: got %0b want 0", irq_a); end
      total++; if (pend_a !== 1'b0) begin bad++; $display("FAIL mr_pend: got %0b want 0", pend_a); end
      total++; if (evt_a !== 4'd0) begin bad++; $display("FAIL mr_evt: got %0d want 0", evt_a); end
      total++; if (miss_a !== 8'd0) begin bad++; $display("FAIL mr_miss: got %0d want 0", miss_a); end
      rst = 1'b1;
      tick();
   endtask

   task automatic test_coalesce();
      thresh = 4'd3;
      ov_in = 1'b1; tick(); ov_in = 1'b0;
`ifdef TIMER_IRQ_COALESCE_EN
      total++; if (evt_a !== 4'd1) begin bad++; $display("FAIL co_evt1: got %0d want 1", evt_a); end
      tick();
      ov_in = 1'b1; tick();
      total++; if (evt_a !== 4'd2) begin bad++; $display("FAIL co_evt2: got %0d want 2", evt_a); end
      total++; if (irq_a !== 1'b0) begin bad++; $display("FAIL co_irq_early: got %0b want 0", irq_a); end
      tick(); ov_in = 1'b0;
      total++; if (irq_a !== 1'b1) begin bad++; $display("FAIL co_irq3: got %0b want 1", irq_a); end
      total++; if (evt_a !== 4'd0) begin bad++; $display("FAIL co_evt0: got %0d want 0", evt_a); end
      release_ack();
      // Lower the threshold below evt_cnt+1: the next event fires.
      thresh = 4'd4;
      ov_in = 1'b1; repeat (2) tick(); ov_in = 1'b0;
      total++; if (evt_a !== 4'd2) begin bad++; $display("FAIL co_low_evt: got %0d want 2", evt_a); end
      thresh = 4'd2;
      ov_in = 1'b1; tick(); ov_in = 1'b0;
      total++; if (pend_a !== 1'b1) begin bad++; $display("FAIL co_low_fire: got %0b want 1", pend_a); end
      release_ack();
      thresh = 4'd0;
      ov_in = 1'b1; tick(); ov_in = 1'b0;
      total++; if (pend_a !== 1'b1) begin bad++; $display("FAIL co_thr0: got %0b want 1", pend_a); end
      release_ack();
`else
      total++; if (irq_a !== 1'b1) begin bad++; $display("FAIL co_irq_nocoal: got %0b want 1", irq_a); end
      total++; if (evt_a !== 4'd0) begin bad++; $display("FAIL co_evt_nocoal: got %0d want 0", evt_a); end
      release_ack();
`endif
   endtask

   task automatic test_miss();
      clr_miss = 1'b1; tick(); clr_miss = 1'b0;
      total++; if (miss_a !== 8'd0) begin bad++; $display("FAIL ms_clr: got %0d want 0", miss_a); end
      fire_one();
      ov_in = 1'b1; repeat (4) tick(); ov_in = 1'b0;
      total++; if (miss_a !== 8'd4) begin bad++; $display("FAIL ms_assert4: got %0d want 4", miss_a); end
      total++; if (pend_a !== 1'b1) begin bad++; $display("FAIL ms_pend_hold: got %0b want 1", pend_a); end
      irq_ack = 1'b1; tick();
      total++; if (irq_a !== 1'b0) begin bad++; $display("FAIL ms_wr_irq: got %0b want 0", irq_a); end
      ov_in = 1'b1; repeat (2) tick(); ov_in = 1'b0;
      total++; if (miss_a !== 8'd6) begin bad++; $display("FAIL ms_total6: got %0d want 6", miss_a); end
      total++; if (pend_a !== 1'b0) begin bad++; $display("FAIL ms_wr_pend: got %0b want 0", pend_a); end
      irq_ack = 1'b0; tick();
      total++; if (pend_a !== 1'b0) begin bad++; $display("FAIL ms_idle_pend: got %0b want 0", pend_a); end
      fire_one();
      total++; if (irq_a !== 1'b1) begin bad++; $display("FAIL ms_refire: got %0b want 1", irq_a); end
      irq_ack = 1'b1; ov_in = 1'b1; tick();
      irq_ack = 1'b0; ov_in = 1'b0;
      total++; if (miss_a !== 8'd7) begin bad++; $display("FAIL ms_ack_coinc: got %0d want 7", miss_a); end
      total++; if (pend_a !== 1'b0) begin bad++; $display("FAIL ms_ack_pend: got %0b want 0", pend_a); end
      tick();
      total++; if (miss_b !== 2'd3) begin bad++; $display("FAIL ms_b_sat: got %0d want 3", miss_b); end
   endtask

   task automatic test_saturate();
      clr_miss = 1'b1; tick(); clr_miss = 1'b0;
      total++; if (miss_b !== 2'd0) begin bad++; $display("FAIL sat_clr: got %0d want 0", miss_b); end
      fire_one();
      ov_in = 1'b1; repeat (5) tick(); ov_in = 1'b0;
      total++; if (miss_b !== 2'd3) begin bad++; $display("FAIL sat_b3: got %0d want 3", miss_b); end
      total++; if (miss_a !== 8'd5) begin bad++; $display("FAIL sat_a5: got %0d want 5", miss_a); end
      clr_miss = 1'b1; ov_in = 1'b1; tick(); clr_miss = 1'b0; ov_in = 1'b0;
      total++; if (miss_b !== 2'd1) begin bad++; $display("FAIL sat_clr_cnt_b: got %0d want 1", miss_b); end
      total++; if (miss_a !== 8'd1) begin bad++; $display("FAIL sat_clr_cnt_a: got %0d want 1", miss_a); end
      release_ack();
   endtask

   task automatic test_mask();
      irq_mask = 1'b1;
      fire_one();
      total++; if (pend_a !== 1'b1) begin bad++; $display("FAIL mk_pend: got %0b want 1", pend_a); end
      total++; if (irq_a !== 1'b0) begin bad++; $display("FAIL mk_irq_gated: got %0b want 0", irq_a); end
      irq_mask = 1'b0;
      #1;
      total++; if (irq_a !== 1'b1) begin bad++; $display("FAIL mk_irq_unmask: got %0b want 1", irq_a); end
      release_ack();
   endtask

   task automatic test_enable();
`ifdef TIMER_IRQ_COALESCE_EN
      thresh = 4'd4;
      ov_in = 1'b1; repeat (2) tick(); ov_in = 1'b0;
      total++; if (evt_a !== 4'd2) begin bad++; $display("FAIL en_evt2: got %0d want 2", evt_a); end
`endif
      en = 1'b0; ov_in = 1'b1; thresh = 4'd1;
      repeat (3) tick();
      ov_in = 1'b0;
      total++; if (evt_a !== 4'd0) begin bad++; $display("FAIL en_evt0: got %0d want 0", evt_a); end
      total++; if (irq_a !== 1'b0) begin bad++; $display("FAIL en_noirq: got %0b want 0", irq_a); end
      en = 1'b1;
      fire_one();
      en = 1'b0; tick();
      total++; if (pend_a !== 1'b0) begin bad++; $display("FAIL en_force_idle: got %0b want 0", pend_a); end
      en = 1'b1; tick();
      thresh = 4'd5;
      ov_in = 1'b1; tick(); ov_in = 1'b0;
`ifdef TIMER_IRQ_COALESCE_EN
      total++; if (evt_a !== 4'd1) begin bad++; $display("FAIL en_thr5_evt: got %0d want 1", evt_a); end
      total++; if (irq_a !== 1'b0) begin bad++; $display("FAIL en_thr5_irq: got %0b want 0", irq_a); end
`else
      total++; if (irq_a !== 1'b1) begin bad++; $display("FAIL en_thr5_irq: got %0b want 1", irq_a); end
      release_ack();
      thresh = 4'd5;
      ov_in = 1'b1; tick(); ov_in = 1'b0;
      total++; if (irq_a !== 1'b1) begin bad++; $display("FAIL en_thr5_irq2: got %0b want 1", irq_a); end
      total++; if (evt_a !== 4'd0) begin bad++; $display("FAIL en_thr5_evt: got %0d want 0", evt_a); end
      release_ack();
`endif
   endtask

   initial begin
      test_reset();
      test_mid_reset();
      test_coalesce();
      test_miss();
      test_saturate();
      test_mask();
      test_enable();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
